// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests and
// buffers up to DEPTH in-flight/returned words ahead of the fetch/decode register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [63:0] fetch_dec_reg,
    output logic        fetch_valid
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW1-1:0] DEPTH_C = CW1'(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_buf_pc  [DEPTH];
    logic [31:0]   r_buf_ins [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_unfilled;
    logic [CW-1:0] r_drop;
    logic [63:0]   r_fdr;
    logic          r_fvalid;

    logic          w_alloc;
    logic          w_fill;
    logic          w_drop_rsp;
    logic          w_pop;
    logic          w_head_filled;
    logic [AW-1:0] w_fill_idx;

    // Entries fill strictly in order, so filled entries always form a prefix
    // of the queue: the head is filled whenever some entry is not unfilled.
    assign w_head_filled = r_count > r_unfilled;
    assign imem_req      = rstn && !redirect_en &&
                           (({1'b0, r_count} + {1'b0, r_drop}) < DEPTH_C);
    assign imem_addr     = r_pc;
    assign w_alloc       = imem_req && imem_gnt;
    assign w_drop_rsp    = imem_rvalid && (r_drop != '0);
    assign w_fill        = imem_rvalid && (r_drop == '0) && (r_unfilled != '0);
    assign w_pop         = !redirect_en && !stall && w_head_filled;
    assign w_fill_idx    = r_wr_ptr - r_unfilled[AW-1:0];

    assign fetch_dec_reg = r_fdr;
    assign fetch_valid   = r_fvalid;

    // Payload storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (!redirect_en) begin
            if (w_alloc) r_buf_pc[r_wr_ptr]    <= r_pc;
            if (w_fill)  r_buf_ins[w_fill_idx] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc       <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_drop     <= '0;
            r_fdr      <= {NOP_INST, 32'h0};
            r_fvalid   <= 1'b0;
        end else if (redirect_en) begin
            // Every request still unanswered after this cycle's response
            // must have its data thrown away when it eventually returns.
            r_pc       <= redirect_pc & ~32'h3;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_drop     <= r_drop + r_unfilled - CW'(w_fill | w_drop_rsp);
            r_fdr      <= {NOP_INST, 32'h0};
            r_fvalid   <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_drop_rsp) r_drop <= r_drop - CW'(1);
            r_count    <= r_count + CW'(w_alloc) - CW'(w_pop);
            r_unfilled <= r_unfilled + CW'(w_alloc) - CW'(w_fill);
            if (!stall) begin
                if (w_pop) begin
                    r_fdr    <= {r_buf_ins[r_rd_ptr], r_buf_pc[r_rd_ptr]};
                    r_fvalid <= 1'b1;
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end else begin
                    r_fdr    <= {NOP_INST, 32'h0};
                    r_fvalid <= 1'b0;
                end
            end
        end
    end
endmodule
